frame_writer: RTL and testbench

Stores one filtered frame into the photo frame buffer. Sits downstream of the colour filters (sepia, etc.). Accepts an 8-bit-per-channel RGB pixel stream and packs each pixel to RGB444. Writes pixels sequentially into a single-port BRAM. On an explicit `start` it captures exactly one frame, aligned to start-of-frame, then reports completion.

---
 rtl/frame_writer.sv | 174 +++++++++++++++++
 tb/tb_frame_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// frame_writer: captures one RGB888 frame, aligned to start-of-frame, into a
// single-port BRAM as packed RGB444 words, one pixel per clock.
// Optional build macro FRAME_WRITER_DITHER_EN adds 2x2 ordered dither before
// truncation to 4 bits per channel; without it the channel MSBs are kept.
module frame_writer #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic              sof,
    input  logic [7:0]        r_in,
    input  logic [7:0]        g_in,
    input  logic [7:0]        b_in,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              sync_err
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept_p0;
    logic              restart_p0;
    logic              last_p0;
    logic [ADDR_W-1:0] addr_cnt;
    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic [ADDR_W-1:0] wr_addr_p0;
    logic [XW-1:0]     wr_x_p0;
    logic [YW-1:0]     wr_y_p0;
    logic [11:0]       wdata_p0;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [11:0]       wdata_p1;

`ifdef FRAME_WRITER_DITHER_EN
    // 2x2 ordered-dither offset indexed by the low coordinate bits
    function automatic logic [3:0] dither_off(input logic y0, input logic x0);
        case ({y0, x0})
            2'b00:   dither_off = 4'd0;
            2'b01:   dither_off = 4'd8;
            2'b10:   dither_off = 4'd12;
            default: dither_off = 4'd4;
        endcase
    endfunction

    // add the offset, clamp at 255, keep the top nibble
    function automatic logic [3:0] dither_sat(input logic [7:0] ch, input logic [3:0] off);
        logic [8:0] sum;
        sum = {1'b0, ch} + {5'b0, off};
        dither_sat = sum[8] ? 4'hF : sum[7:4];
    endfunction

    logic [3:0] off_p0;
    assign off_p0   = dither_off(wr_y_p0[0], wr_x_p0[0]);
    assign wdata_p0 = {dither_sat(r_in, off_p0), dither_sat(g_in, off_p0), dither_sat(b_in, off_p0)};
`else
    assign wdata_p0 = {r_in[7:4], g_in[7:4], b_in[7:4]};

    // channel LSBs are discarded by plain truncation
    logic unused_lsbs;
    assign unused_lsbs = ^{r_in[3:0], g_in[3:0], b_in[3:0]};
`endif

    // DONE is still reported busy so busy drops exactly when done rises
    assign busy = (state != IDLE);

    // Next-state logic, pixel acceptance and coordinates of the pixel written
    always_comb begin
        state_nxt  = state;
        accept_p0  = 1'b0;
        restart_p0 = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ARMED;
            end
            ARMED: begin
                if (pix_valid && sof) begin
                    accept_p0  = 1'b1;
                    restart_p0 = 1'b1;
                    state_nxt  = WRITE;
                end
            end
            WRITE: begin
                if (pix_valid) begin
                    accept_p0  = 1'b1;
                    restart_p0 = sof;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // a sof pixel always lands at the origin, whatever the counters hold
        wr_addr_p0 = restart_p0 ? '0 : addr_cnt;
        wr_x_p0    = restart_p0 ? '0 : x_cnt;
        wr_y_p0    = restart_p0 ? '0 : y_cnt;
        last_p0    = (wr_x_p0 == X_LAST) && (wr_y_p0 == Y_LAST);
        if (accept_p0 && last_p0) state_nxt = DONE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Address and raster counters point at the next expected pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else if (accept_p0) begin
            addr_cnt <= last_p0 ? '0 : wr_addr_p0 + ADDR_W'(1);
            if (wr_x_p0 == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (wr_y_p0 == Y_LAST) ? '0 : wr_y_p0 + YW'(1);
            end else begin
                x_cnt <= wr_x_p0 + XW'(1);
                y_cnt <= wr_y_p0;
            end
        end
    end

    // Stage p0 -> p1: registered BRAM write port
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                addr_p1  <= wr_addr_p0;
                wdata_p1 <= wdata_p0;
            end
        end
    end

    assign we    = vld_p1;
    assign addr  = addr_p1;
    assign wdata = wdata_p1;

    // Completion pulse trails the DONE state; sync_err is sticky until a new capture
    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == IDLE && start)
                sync_err <= 1'b0;
            else if (state == WRITE && pix_valid && sof)
                sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed scenarios plus a randomized stream for
// frame_writer (4x2 frame), checked every cycle against a transaction-level
// reference model that tracks the frame by pixel index.
module tb_frame_writer;

    localparam int H = 4;
    localparam int V = 2;
    localparam int AW = 3;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic [7:0]    r_in = '0, g_in = '0, b_in = '0;
    logic          we;
    logic [AW-1:0] addr;
    logic [11:0]   wdata;
    logic          busy, done, sync_err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: 0 idle, 1 waiting for sof, 2 capturing, 3 finishing
    int          m_phase = 0;
    int          m_next = 0;
    logic        e_we = 0, e_busy = 0, e_done = 0, e_sync = 0;
    logic [31:0] e_addr = 0, e_wdata = 0;

    frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .sof(sof),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pack_ch(input logic [7:0] c, input int x, input int y);
        int s;
`ifdef FRAME_WRITER_DITHER_EN
        int off;
        if (y % 2 == 0) off = (x % 2 == 0) ? 0 : 8;
        else            off = (x % 2 == 0) ? 12 : 4;
        s = int'(c) + off;
        if (s > 255) s = 255;
`else
        s = int'(c);
`endif
        return 4'(s / 16);
    endfunction

    // expected outputs after the coming clock edge, given this cycle's inputs
    task automatic model_step(input bit i_rst, i_start, i_pv, i_sof,
                              input logic [7:0] i_r, i_g, i_b);
        int idx;
        bit acc;
        if (i_rst) begin
            m_phase = 0; m_next = 0;
            e_we = 0; e_addr = 0; e_wdata = 0; e_done = 0; e_sync = 0;
        end else begin
            acc = 0;
            idx = 0;
            e_done = (m_phase == 3);
            case (m_phase)
                0: if (i_start) begin m_phase = 1; e_sync = 0; end
                1: if (i_pv && i_sof) begin acc = 1; idx = 0; end
                2: if (i_pv) begin
                       if (i_sof) begin e_sync = 1; idx = 0; end
                       else idx = m_next;
                       acc = 1;
                   end
                default: m_phase = 0;
            endcase
            e_we = acc;
            if (acc) begin
                e_addr  = idx;
                e_wdata = {20'd0, pack_ch(i_r, idx % H, idx / H),
                           pack_ch(i_g, idx % H, idx / H), pack_ch(i_b, idx % H, idx / H)};
                m_next  = idx + 1;
                m_phase = (idx == NPIX - 1) ? 3 : 2;
            end
        end
        e_busy = (m_phase != 0);
    endtask

    task automatic cycle(input bit i_rst, i_start, i_pv, i_sof,
                         input logic [7:0] i_r, i_g, i_b);
        rst = i_rst; start = i_start; pix_valid = i_pv; sof = i_sof;
        r_in = i_r; g_in = i_g; b_in = i_b;
        model_step(i_rst, i_start, i_pv, i_sof, i_r, i_g, i_b);
        @(posedge clk);
        #1;
        chk("we", {31'd0, we}, {31'd0, e_we});
        chk("addr", {29'd0, addr}, e_addr);
        chk("wdata", {20'd0, wdata}, e_wdata);
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("done", {31'd0, done}, {31'd0, e_done});
        chk("sync_err", {31'd0, sync_err}, {31'd0, e_sync});
    endtask

    task automatic idle_cyc();
        cycle(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic px(input bit s, input logic [7:0] r, g, b);
        cycle(0, 0, 1, s, r, g, b);
    endtask

    // mode 0: k-indexed pattern; 1: all 0xF6; 2: all 0x78
    task automatic send_frame(input int mode, input bit gapped);
        logic [7:0] v;
        for (int k = 0; k < NPIX; k++) begin
            if (mode == 0) px(k == 0, 8'(16 * k + 5), 8'hFF, 8'h0F);
            else begin
                v = (mode == 1) ? 8'hF6 : 8'h78;
                px(k == 0, v, v, v);
            end
            if (gapped) idle_cyc();
        end
    endtask

    int n_we_seen;

    initial begin
        // reset held for a few cycles
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 8'hAA, 8'hBB, 8'hCC);

        // idle: pixels and sof pulses without start are dropped
        for (int i = 0; i < 10; i++) px(i % 4 == 0, 8'(i), 8'hFF, 8'h10);

        // full capture with done timing
        cycle(0, 1, 0, 0, 0, 0, 0);
        send_frame(0, 0);
        idle_cyc();
        idle_cyc();

        // gapped stream
        cycle(0, 1, 0, 0, 0, 0, 0);
        send_frame(0, 1);
        idle_cyc();

        // sof coincident with start is not captured
        cycle(0, 1, 1, 1, 8'h11, 8'h22, 8'h33);
        send_frame(1, 0);
        idle_cyc();

        // mid-frame sof: sync_err set, survives done, cleared by next start
        cycle(0, 1, 0, 0, 0, 0, 0);
        px(1, 8'h10, 8'h20, 8'h30);
        px(0, 8'h40, 8'h50, 8'h60);
        px(0, 8'h70, 8'h80, 8'h90);
        send_frame(2, 0);
        idle_cyc();
        idle_cyc();
        cycle(0, 1, 0, 0, 0, 0, 0);
        idle_cyc();

        // reset after the addr-3 write, then sof pixels without start
        send_frame(0, 0);
        idle_cyc();
        cycle(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) px(k == 0, 8'hC3, 8'h3C, 8'h99);
        cycle(1, 0, 1, 0, 8'hFF, 8'hFF, 8'hFF);
        n_we_seen = 0;
        for (int k = 0; k < 8; k++) begin
            px(k % 3 == 0, 8'hFF, 8'h00, 8'hFF);
            if (we) n_we_seen++;
        end
        chk("writes_after_rst", 32'(n_we_seen), 32'd0);

        // randomized stream
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 14) == 0),
                  8'($urandom), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 4; i++) idle_cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
